// File: rtl/fft2_bfly_pipe.sv
// Pipelined radix-2 DIT butterfly, valid/ready, 3 register stages.
// Define FFT2_SAT_EN for saturating outputs and the sticky ovf flag.
module fft2_bfly_pipe #(
    parameter int WIDTH = 24,
    parameter int FRAC  = WIDTH/2-1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x0_in,
    input  logic [WIDTH-1:0] x1_in,
    input  logic [WIDTH-1:0] coef_in,
    input  logic             inv_in,
    input  logic             scale_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x0_out,
    output logic [WIDTH-1:0] x1_out,
    output logic             ovf,
    input  logic             ovf_clr
);
    localparam int H = WIDTH/2;
    localparam int P = 2*H+1;
    localparam int E = H+2;

    typedef logic signed [H-1:0]   h_t;
    typedef logic signed [H:0]     q_t;
    typedef logic signed [2*H-1:0] m_t;
    typedef logic signed [P-1:0]   p_t;
    typedef logic signed [E-1:0]   e_t;

    localparam h_t HMAX   = {1'b0, {(H-1){1'b1}}};
    localparam h_t HMIN   = {1'b1, {(H-1){1'b0}}};
    localparam e_t LIM_HI = {3'b000, {(H-1){1'b1}}};
    localparam e_t LIM_LO = {3'b111, {(H-1){1'b0}}};
    localparam e_t ONE_E  = {{(E-1){1'b0}}, 1'b1};
    localparam p_t RND    = {{(P-1){1'b0}}, 1'b1} << (FRAC-1);

    logic en;
    logic s1_v, s2_v, s3_v;

    assign en        = !s3_v || out_ready;
    assign in_ready  = en;
    assign out_valid = s3_v;

    // S1: capture inputs, conjugate the twiddle in inverse mode
    h_t c_im, wi_n;

    always_comb begin
        c_im = coef_in[H-1:0];
        wi_n = c_im;
        if (inv_in)
            wi_n = (c_im == HMIN) ? HMAX : -c_im;
    end

    logic [WIDTH-1:0] s1_x0, s1_x1;
    h_t               s1_wr, s1_wi;
    logic             s1_sc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v  <= 1'b0;
            s1_x0 <= '0;
            s1_x1 <= '0;
            s1_wr <= '0;
            s1_wi <= '0;
            s1_sc <= 1'b0;
        end else if (en) begin
            s1_v  <= in_valid;
            s1_x0 <= x0_in;
            s1_x1 <= x1_in;
            s1_wr <= coef_in[WIDTH-1:H];
            s1_wi <= wi_n;
            s1_sc <= scale_in;
        end
    end

    // S2: full-precision complex multiply, round, keep H+1 bits
    h_t xr, xi;
    m_t m_rr, m_ii, m_ri, m_ir;
    p_t pr_r, pi_r, pr_s, pi_s;

    always_comb begin
        xr   = s1_x1[WIDTH-1:H];
        xi   = s1_x1[H-1:0];
        m_rr = m_t'(s1_wr) * m_t'(xr);
        m_ii = m_t'(s1_wi) * m_t'(xi);
        m_ri = m_t'(s1_wr) * m_t'(xi);
        m_ir = m_t'(s1_wi) * m_t'(xr);
        pr_r = p_t'(m_rr) - p_t'(m_ii) + RND;
        pi_r = p_t'(m_ri) + p_t'(m_ir) + RND;
        pr_s = pr_r >>> FRAC;
        pi_s = pi_r >>> FRAC;
    end

    logic [WIDTH-1:0] s2_x0;
    q_t               s2_pr, s2_pi;
    logic             s2_sc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v  <= 1'b0;
            s2_x0 <= '0;
            s2_pr <= '0;
            s2_pi <= '0;
            s2_sc <= 1'b0;
        end else if (en) begin
            s2_v  <= s1_v;
            s2_x0 <= s1_x0;
            s2_pr <= pr_s[H:0];
            s2_pi <= pi_s[H:0];
            s2_sc <= s1_sc;
        end
    end

    // S3: sum/difference, optional rounded halving, reduce to H bits
    function automatic e_t bf(input h_t a, input q_t p,
                              input logic sub, input logic sc);
        e_t v;
        e_t t;
        v = sub ? (e_t'(a) - e_t'(p)) : (e_t'(a) + e_t'(p));
        t = v + ONE_E;
        return sc ? (t >>> 1) : v;
    endfunction

    function automatic logic oor(input e_t v);
        return (v > LIM_HI) || (v < LIM_LO);
    endfunction

    function automatic h_t red(input e_t v);
`ifdef FFT2_SAT_EN
        if (v > LIM_HI)
            return HMAX;
        else if (v < LIM_LO)
            return HMIN;
        else
            return v[H-1:0];
`else
        return v[H-1:0];
`endif
    endfunction

    h_t   x0r, x0i;
    e_t   y0r, y0i, y1r, y1i;
    logic ov_any;

    always_comb begin
        x0r    = s2_x0[WIDTH-1:H];
        x0i    = s2_x0[H-1:0];
        y0r    = bf(x0r, s2_pr, 1'b0, s2_sc);
        y0i    = bf(x0i, s2_pi, 1'b0, s2_sc);
        y1r    = bf(x0r, s2_pr, 1'b1, s2_sc);
        y1i    = bf(x0i, s2_pi, 1'b1, s2_sc);
        ov_any = oor(y0r) || oor(y0i) || oor(y1r) || oor(y1i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_v   <= 1'b0;
            x0_out <= '0;
            x1_out <= '0;
        end else if (en) begin
            s3_v   <= s2_v;
            x0_out <= {red(y0r), red(y0i)};
            x1_out <= {red(y1r), red(y1i)};
        end
    end

`ifdef FFT2_SAT_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (en && s2_v && ov_any)
            ovf_q <= 1'b1;
        else if (ovf_clr)
            ovf_q <= 1'b0;
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf;

    assign unused_ovf = ovf_clr ^ ov_any;
    assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_fft2_bfly_pipe.sv
// Directed bench for fft2_bfly_pipe (WIDTH=24, FRAC=11).
// Expected results are hand-derived; saturation cases follow FFT2_SAT_EN.
module tb_fft2_bfly_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [23:0] x0_in, x1_in, coef_in;
    logic        inv_in, scale_in;
    logic        out_valid, out_ready;
    logic [23:0] x0_out, x1_out;
    logic        ovf, ovf_clr;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef FFT2_SAT_EN
    localparam int SAT_Y0  = 2047;
    localparam bit SAT_OVF = 1'b1;
`else
    localparam int SAT_Y0  = -3;
    localparam bit SAT_OVF = 1'b0;
`endif

    fft2_bfly_pipe #(.WIDTH(24), .FRAC(11)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x0_in     (x0_in),
        .x1_in     (x1_in),
        .coef_in   (coef_in),
        .inv_in    (inv_in),
        .scale_in  (scale_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x0_out    (x0_out),
        .x1_out    (x1_out),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [23:0] pk(input int re, input int im);
        logic [11:0] r;
        logic [11:0] i;
        r = re[11:0];
        i = im[11:0];
        return {r, i};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one pair with out_ready high; checks latency and both results
    task automatic send(input string tag, input logic [23:0] a,
                        input logic [23:0] b, input logic [23:0] w,
                        input logic iv, input logic sc,
                        input logic [23:0] e0, input logic [23:0] e1);
        int n;
        in_valid = 1'b1;
        x0_in    = a;
        x1_in    = b;
        coef_in  = w;
        inv_in   = iv;
        scale_in = sc;
        check({tag, ".rdy"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        check({tag, ".lat"}, 32'(n), 32'd3);
        check({tag, ".y0"}, 32'(x0_out), 32'(e0));
        check({tag, ".y1"}, 32'(x1_out), 32'(e1));
    endtask

    initial begin
        logic [23:0] exp0 [8];
        logic [23:0] exp1 [8];
        logic [23:0] hold_v;
        logic        held;
        int          sent, rcv, cyc, extra;

        rst       = 1'b1;
        in_valid  = 1'b0;
        x0_in     = '0;
        x1_in     = '0;
        coef_in   = '0;
        inv_in    = 1'b0;
        scale_in  = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check("rst.vld", 32'(out_valid), 32'd0);
        check("rst.rdy", 32'(in_ready), 32'd1);
        check("rst.y0", 32'(x0_out), 32'd0);
        check("rst.y1", 32'(x1_out), 32'd0);
        check("rst.ovf", 32'(ovf), 32'd0);

        send("fwd", pk(100, 0), pk(50, 0), pk(2047, 0), 1'b0, 1'b0,
             pk(150, 0), pk(50, 0));
        send("inv", pk(100, 0), pk(50, 0), pk(0, 2047), 1'b1, 1'b0,
             pk(100, -50), pk(100, 50));
        send("sat", pk(2047, 0), pk(2047, 0), pk(2047, 0), 1'b0, 1'b0,
             pk(SAT_Y0, 0), pk(1, 0));
        check("sat.ovf", 32'(ovf), 32'(SAT_OVF));
        step();
        step();
        check("sat.ovf_hold", 32'(ovf), 32'(SAT_OVF));
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("sat.ovf_clr", 32'(ovf), 32'd0);

        send("scl", pk(2047, 0), pk(2047, 0), pk(2047, 0), 1'b0, 1'b1,
             pk(2047, 0), pk(1, 0));
        check("scl.ovf", 32'(ovf), 32'd0);
        step();

        // backpressure stream: y0 = 11*k, y1 = 9*k for k = 1..8
        for (int i = 0; i < 8; i++) begin
            exp0[i] = pk(11 * (i + 1), 0);
            exp1[i] = pk(9 * (i + 1), 0);
        end
        sent = 0;
        rcv  = 0;
        cyc  = 0;
        held = 1'b0;
        hold_v = '0;
        while (rcv < 8 && cyc < 300) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 8);
            x0_in     = pk(10 * (sent + 1), 0);
            x1_in     = pk(sent + 1, 0);
            coef_in   = pk(2047, 0);
            inv_in    = 1'b0;
            scale_in  = 1'b0;
            #1;
            check("bp.rdy", 32'(in_ready), 32'(!out_valid || out_ready));
            if (held)
                check("bp.hold", 32'(x0_out), 32'(hold_v));
            held   = out_valid && !out_ready;
            hold_v = x0_out;
            if (out_valid && out_ready) begin
                check("bp.y0", 32'(x0_out), 32'(exp0[rcv]));
                check("bp.y1", 32'(x1_out), 32'(exp1[rcv]));
                rcv++;
            end
            if (in_valid && in_ready)
                sent++;
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp.count", 32'(rcv), 32'd8);
        extra = 0;
        repeat (6) begin
            if (out_valid)
                extra++;
            step();
        end
        check("bp.extra", 32'(extra), 32'd0);

        // reset with three pairs in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            x0_in    = pk(20 + i, 0);
            x1_in    = pk(1, 0);
            coef_in  = pk(2047, 0);
            step();
        end
        check("mid.vld_pre", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid.vld", 32'(out_valid), 32'd0);
        check("mid.y0", 32'(x0_out), 32'd0);
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        extra = 0;
        repeat (6) begin
            step();
            if (out_valid)
                extra++;
        end
        check("mid.stale", 32'(extra), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft2_bfly_pipe.md
# fft2_bfly_pipe

Pipelined, parametrised radix-2 decimation-in-time butterfly with valid/ready flow control. It computes y0 = x0 + W·x1 and y1 = x0 − W·x1 on packed complex samples. Options cover inverse (conjugate-twiddle) mode, per-pair 1/2 scaling and saturation with a sticky overflow flag. It is the reusable stage element for the next-generation streaming FFT cores: it replaces the fixed 24-bit, stall-only 2-point stage with a backpressure-capable, width-generic block.

## Interface
- WIDTH, 24, packed complex sample width; re = [WIDTH-1:H], im = [H-1:0], H = WIDTH/2; must be even, ≥ 8.
- FRAC, WIDTH/2-1, twiddle fractional bits; twiddle parts are signed Q1.FRAC, H bits each.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input pair + controls valid.
- in_ready  out  1  block accepts the input this cycle.
- x0_in  in  WIDTH  upper butterfly input.
- x1_in  in  WIDTH  lower butterfly input.
- coef_in  in  WIDTH  twiddle W, packed like the samples.
- inv_in  in  1  1 = use conj(W); travels with the pair.
- scale_in  in  1  1 = halve both results; travels with the pair.
- out_valid  out  1  output pair valid.
- out_ready  in  1  downstream accepts the output.
- x0_out  out  WIDTH  y0.
- x1_out  out  WIDTH  y1.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  synchronous clear of ovf.

## Operation
- The pipeline has 3 register stages, S1, S2 and S3; each stage holds a valid bit.
- Global enable: en = !out_valid | out_ready. All stages advance only when en = 1. in_ready = en, combinationally.
- A transfer in or out occurs when valid & ready are both 1 on a rising edge.
- S1 registers x0, x1, scale and the twiddle. When inv_in = 1, the twiddle im part is negated. Negating −2^(H−1) saturates to 2^(H−1)−1.
- S2 computes the complex product P = W·x1 at full precision (2H+1 bits):
  - pr = wr·xr − wi·xi; pi = wr·xi + wi·xr.
  - Rounding: add 2^(FRAC−1), then arithmetic shift right by FRAC, keeping H+1 bits.
  - x0 is delayed alongside.
- S3 computes the results:
  - s = x0 + P and d = x0 − P, per part, H+2 bits sign-extended.
  - If scale is set: add 1, then arithmetic shift right by 1.
  - The result is then reduced to H bits (see Configuration).
- ovf is set when any part of an accepted output pair exceeds the H-bit signed range. It stays set until ovf_clr. If ovf_clr and a new overflow occur in the same cycle, set wins.
- Reset state: all valid bits 0, all data registers 0, ovf 0. Therefore out_valid = 0, x0_out = x1_out = 0 and in_ready = 1.
- Reset asserted mid-operation discards every in-flight pair; no partial output is produced.

## Timing
- Latency is 3 cycles: a pair accepted at edge k appears on out_valid/x*_out after edge k+3, provided en stays 1.
- Throughput is 1 pair/cycle when out_ready is held at 1.
- out_ready = 0 with out_valid = 1 freezes all stages. x*_out remain stable, in_ready = 0, and no data is lost or duplicated.
- Bubbles (invalid stages) still advance only when en = 1; they are not collapsed.
- ovf updates on the edge at which the offending pair enters S3's output register.

## Configuration
- FFT2_SAT_EN defined: S3 clamps each part to [−2^(H−1), 2^(H−1)−1], and ovf operates as described.
- FFT2_SAT_EN undefined: S3 keeps the low H bits (two's-complement wrap), ovf is tied to 0, and ovf_clr is ignored.

## Test plan
All cases use WIDTH=24, FRAC=11, and FFT2_SAT_EN defined unless noted.
- Reset release:
  - Stimulus: apply reset, then release it.
  - Response: out_valid = 0, in_ready = 1, outputs 0, ovf = 0.
- Forward butterfly:
  - Stimulus: x0 = (100, 0), x1 = (50, 0), W = (2047, 0), inv = 0, scale = 0.
  - Response: after 3 cycles, y0 = (150, 0) and y1 = (50, 0).
- Inverse mode:
  - Stimulus: x0 = (100, 0), x1 = (50, 0), W = (0, 2047), inv = 1.
  - Response: y0 = (100, −50) and y1 = (100, 50).
- Saturation:
  - Stimulus: x0 = x1 = (2047, 0), W = (2047, 0), scale = 0.
  - Response: y0 = (2047, 0) saturated, y1 = (1, 0), ovf = 1. ovf stays 1 until ovf_clr is pulsed, then reads 0.
- Scaling:
  - Stimulus: the saturation stimulus with scale = 1.
  - Response: y0 = (2047, 0), y1 = (1, 0), ovf remains 0.
- Backpressure:
  - Stimulus: stream 8 consecutive pairs while toggling out_ready pseudo-randomly; then assert reset during the stream.
  - Response: all 8 outputs emerge in order with no loss or duplication, and in_ready mirrors en. After the reset, out_valid = 0 immediately and no stale pair appears afterwards.
